rpm_error_calc: RTL and testbench

Upstream stage of the PI speed controller, one instance per motor. Decodes the quadrature encoder and counts edges over a fixed sample window. Converts the window count to a signed speed and subtracts it from the RPM setpoint. Outputs the error as 17-bit sign-magnitude Q8, plus a one-cycle sample strobe that paces the controller.

---
 rtl/rpm_error_calc.sv | 198 +++++++++++++++++++
 tb/tb_rpm_error_calc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rpm_error_calc.sv
`default_nettype none
// ============================================================================
// rpm_error_calc : quadrature decode, windowed speed, sign-magnitude error
//   Optional macro ENC_GLITCH_FILTER_EN adds a per-channel stability filter.
//   Rev 1.0
// ============================================================================
module rpm_error_calc #(
  parameter int unsigned SAMPLE_CYCLES    = 4100,
  parameter int unsigned COUNT_W          = 16,
  parameter logic [15:0] RPM_PER_COUNT_Q8 = 16'h0100,
  parameter int unsigned N_WIDTH          = 17,
  parameter int unsigned FILTER_LEN       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic [N_WIDTH-1:0] setpoint,
  output logic               sample_tick,
  output logic [N_WIDTH-1:0] error_k,
  output logic               error_valid,
  output logic [N_WIDTH-1:0] speed_meas,
  output logic [7:0]         illegal_cnt
);

  localparam int unsigned MAG_W  = N_WIDTH - 1;
  localparam int unsigned PRE_W  = $clog2(SAMPLE_CYCLES);
  localparam int unsigned PROD_W = COUNT_W + 16;
  localparam logic [PRE_W-1:0]          PRE_LAST = PRE_W'(SAMPLE_CYCLES - 1);
  localparam logic signed [COUNT_W-1:0] CNT_MAX  = {1'b0, {(COUNT_W-1){1'b1}}};
  localparam logic signed [COUNT_W-1:0] CNT_MIN  = -CNT_MAX;
  localparam logic signed [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [MAG_W-1:0]          MAG_SAT  = '1;

  // Channel conditioning: bit 1 = A, bit 0 = B
  logic [1:0] enc_in;
  logic [1:0] ab_dec;
  assign enc_in = {enc_a, enc_b};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[0], enc_in[ch]};
    always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
    end
`ifdef ENC_GLITCH_FILTER_EN
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    logic [FLT_W-1:0] run_q, run_d;
    logic             filt_q, filt_d;
    // run_q counts consecutive cycles the synchronized level differs from filt_q
    always_comb begin
      run_d  = '0;
      filt_d = filt_q;
      if (sync_q[1] != filt_q) begin
        if (run_q == FLT_W'(FILTER_LEN - 1)) filt_d = sync_q[1];
        else                                 run_d  = run_q + 1'b1;
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        run_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        run_q  <= run_d;
        filt_q <= filt_d;
      end
    end
    assign ab_dec[ch] = filt_q;
`else
    assign ab_dec[ch] = sync_q[1];
`endif
  end

  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  logic [1:0]                prev_ab_q, prev_ab_d;
  logic                      prev_ok_q, prev_ok_d;
  logic [PRE_W-1:0]          presc_q, presc_d;
  logic signed [COUNT_W-1:0] cnt_q, cnt_d, cnt_upd;
  logic [7:0]                ill_q, ill_d;
  logic [N_WIDTH-1:0]        speed_q, speed_d;
  logic [N_WIDTH-1:0]        sp_snap_q, sp_snap_d;
  logic                      en_snap_q, en_snap_d;
  logic                      p1_q, p1_d;
  logic [N_WIDTH-1:0]        err_q, err_d;
  logic                      err_valid_q, err_valid_d;

  logic [1:0]         pos_diff;
  logic               step_fwd, step_rev, step_ill, tick;
  logic [COUNT_W-1:0] cnt_abs;
  logic [PROD_W-1:0]  prod;
  logic [MAG_W-1:0]   spd_mag, sp_mag, ns_mag, res_mag;
  logic               spd_sign, sp_sign, ns_sign, res_sign;
  logic [MAG_W:0]     mag_sum;

  always_comb begin
    tick      = (presc_q == PRE_LAST);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    prev_ab_d = ab_dec;
    prev_ok_d = 1'b1;

    pos_diff = gray_pos(ab_dec) - gray_pos(prev_ab_q);
    step_fwd = prev_ok_q && (pos_diff == 2'd1);
    step_rev = prev_ok_q && (pos_diff == 2'd3);
    step_ill = prev_ok_q && (pos_diff == 2'd2);

    // cnt_upd includes the step decoded this cycle, so it is the tick snapshot
    cnt_upd = cnt_q;
    if (step_fwd && (cnt_q != CNT_MAX))      cnt_upd = cnt_q + CNT_ONE;
    else if (step_rev && (cnt_q != CNT_MIN)) cnt_upd = cnt_q - CNT_ONE;
    if (!enable) cnt_upd = '0;
    cnt_d = tick ? '0 : cnt_upd;

    ill_d = ill_q;
    if (enable && step_ill && (ill_q != 8'hFF)) ill_d = ill_q + 8'd1;

    // Integer count times Q8 scale is already Q8; no shift needed
    cnt_abs  = cnt_upd[COUNT_W-1] ? COUNT_W'(-cnt_upd) : COUNT_W'(cnt_upd);
    prod     = PROD_W'(cnt_abs) * PROD_W'(RPM_PER_COUNT_Q8);
    spd_mag  = (prod > PROD_W'(MAG_SAT)) ? MAG_SAT : prod[MAG_W-1:0];
    spd_sign = cnt_upd[COUNT_W-1] && (spd_mag != '0);

    speed_d   = tick ? {spd_sign, spd_mag} : speed_q;
    sp_snap_d = tick ? setpoint : sp_snap_q;
    en_snap_d = tick ? enable : en_snap_q;
    p1_d      = tick;

    // error = setpoint + (-speed), all in sign-magnitude
    sp_sign = sp_snap_q[N_WIDTH-1];
    sp_mag  = sp_snap_q[MAG_W-1:0];
    ns_sign = ~speed_q[N_WIDTH-1];
    ns_mag  = speed_q[MAG_W-1:0];
    mag_sum = {1'b0, sp_mag} + {1'b0, ns_mag};
    if (sp_sign == ns_sign) begin
      res_mag  = mag_sum[MAG_W] ? MAG_SAT : mag_sum[MAG_W-1:0];
      res_sign = sp_sign;
    end else if (sp_mag >= ns_mag) begin
      res_mag  = sp_mag - ns_mag;
      res_sign = sp_sign;
    end else begin
      res_mag  = ns_mag - sp_mag;
      res_sign = ns_sign;
    end
    if (res_mag == '0) res_sign = 1'b0;
    if (!en_snap_q) begin
      res_mag  = '0;
      res_sign = 1'b0;
    end

    err_d       = p1_q ? {res_sign, res_mag} : err_q;
    err_valid_d = p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ab_q   <= '0;
      prev_ok_q   <= 1'b0;
      presc_q     <= '0;
      cnt_q       <= '0;
      ill_q       <= '0;
      speed_q     <= '0;
      sp_snap_q   <= '0;
      en_snap_q   <= 1'b0;
      p1_q        <= 1'b0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
    end else begin
      prev_ab_q   <= prev_ab_d;
      prev_ok_q   <= prev_ok_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      ill_q       <= ill_d;
      speed_q     <= speed_d;
      sp_snap_q   <= sp_snap_d;
      en_snap_q   <= en_snap_d;
      p1_q        <= p1_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign sample_tick = tick;
  assign error_k     = err_q;
  assign error_valid = err_valid_q;
  assign speed_meas  = speed_q;
  assign illegal_cnt = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_rpm_error_calc.sv
`default_nettype none
// ============================================================================
// tb_rpm_error_calc : scoreboard bench for rpm_error_calc (directed windows)
//   Rev 1.0
// ============================================================================
module tb_rpm_error_calc;

  localparam int SC = 4100;
  localparam int NW = 17;

  logic          clk = 1'b0;
  logic          reset, enable, enc_a, enc_b;
  logic [NW-1:0] setpoint;
  logic          sample_tick, error_valid;
  logic [NW-1:0] error_k, speed_meas;
  logic [7:0]    illegal_cnt;

  rpm_error_calc #(
    .SAMPLE_CYCLES   (SC),
    .COUNT_W         (16),
    .RPM_PER_COUNT_Q8(16'h0100),
    .N_WIDTH         (NW),
    .FILTER_LEN      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .setpoint   (setpoint),
    .sample_tick(sample_tick),
    .error_k    (error_k),
    .error_valid(error_valid),
    .speed_meas (speed_meas),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NW-1:0] err;
    logic [NW-1:0] spd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned tick_cyc = 0;
  logic [1:0]  pos      = 2'd0;
  logic        h1       = 1'b0;
  logic        h2       = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] gray(input logic [1:0] p);
    case (p)
      2'd0:    gray = 2'b00;
      2'd1:    gray = 2'b10;
      2'd2:    gray = 2'b11;
      default: gray = 2'b01;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [NW-1:0] err, input logic [NW-1:0] spd);
    exp_t e;
    e.err = err;
    e.spd = spd;
    exp_q.push_back(e);
  endtask

  task automatic steps(input int n, input bit fwd, input int gap);
    for (int i = 0; i < n; i++) begin
      pos = fwd ? pos + 2'd1 : pos - 2'd1;
      {enc_a, enc_b} = gray(pos);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic illegal_jump();
    pos = pos + 2'd2;
    {enc_a, enc_b} = gray(pos);
    repeat (4) @(negedge clk);
  endtask

  // Returns one cycle after the tick, so the snapshot edge has already passed
  task automatic next_window();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 2 * SC);
    if (sample_tick) tick_cyc = cyc;
    else begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: got no tick expected tick within %0d cycles", 2 * SC);
    end
    @(negedge clk);
  endtask

  // Called on the negedge right after reset release; that cycle is number 1
  task automatic count_to_tick(output int n);
    n = 1;
    while (!sample_tick && n < 2 * SC) begin
      @(negedge clk);
      n++;
    end
    tick_cyc = cyc;
  endtask

  task automatic wait_until(input int unsigned off);
    while (cyc < tick_cyc + off) @(negedge clk);
  endtask

  // Monitor: error_valid must trail sample_tick by two cycles; pop and compare
  always @(negedge clk) begin
    if (reset) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      if (error_valid || h2) check("valid_align", 32'(error_valid), 32'(h2));
      if (error_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got error_k=%h expected no error_valid", error_k);
        end else begin
          mon_e = exp_q.pop_front();
          check("error_k", 32'(error_k), 32'(mon_e.err));
          check("speed_meas", 32'(speed_meas), 32'(mon_e.spd));
        end
      end
      h2 = h1;
      h1 = sample_tick;
    end
  end

  initial begin
    int n;
    reset    = 1'b1;
    enable   = 1'b1;
    enc_a    = 1'b0;
    enc_b    = 1'b0;
    setpoint = '0;
    repeat (3) @(negedge clk);
    check("reset_error_k", 32'(error_k), 32'h0);
    check("reset_speed", 32'(speed_meas), 32'h0);
    check("reset_illegal", 32'(illegal_cnt), 32'h0);
    check("reset_valid", 32'(error_valid), 32'h0);
    check("reset_tick", 32'(sample_tick), 32'h0);

    // Window 1: idle
    push_exp(17'h00000, 17'h00000);
    reset = 1'b0;
    count_to_tick(n);
    check("first_tick_cycle", 32'(n), 32'(SC));
    @(negedge clk);

    // Window 2: +20.0 setpoint, 10 forward steps
    setpoint = 17'h01400;
    push_exp(17'h00A00, 17'h00A00);
    steps(10, 1'b1, 50);
    next_window();

    // Window 3: 30 reverse steps -> -30.0 measured, +50.0 error
    push_exp(17'h03200, 17'h11E00);
    steps(30, 1'b0, 20);
    next_window();

    // Window 4: 300 forward steps saturate speed; negative setpoint saturates error
    setpoint = 17'h1FF00;
    push_exp(17'h1FFFF, 17'h0FFFF);
    steps(300, 1'b1, 4);
    next_window();

    // Window 5: illegal jump, 3 steps, plus one step decoded in the tick cycle
    setpoint = 17'h00500;
    push_exp(17'h00100, 17'h00400);
    illegal_jump();
    check("illegal_cnt_one", 32'(illegal_cnt), 32'h1);
    steps(3, 1'b1, 4);
    wait_until(SC - 2);
    steps(1, 1'b1, 1);
    steps(1, 1'b1, 1);
    check("edge_tick", 32'(sample_tick), 32'h1);
    tick_cyc = cyc;
    @(negedge clk);

    // Window 6: only the T+1 step lands here; setpoint 0 -> -1.0
    setpoint = 17'h00000;
    push_exp(17'h10100, 17'h00100);
    next_window();

    // Window 7: enable low, steps ignored, illegal_cnt frozen
    enable   = 1'b0;
    setpoint = 17'h01400;
    push_exp(17'h00000, 17'h00000);
    steps(5, 1'b1, 10);
    illegal_jump();
    check("illegal_cnt_frozen", 32'(illegal_cnt), 32'h1);
    next_window();

    // Window 8: reset 2000 cycles in discards it; the post-reset window reports
    enable   = 1'b1;
    setpoint = 17'h00300;
    push_exp(17'h00300, 17'h00000);
    while (pos != 2'd0) steps(1, 1'b1, 4);
    wait_until(2000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_clears_illegal", 32'(illegal_cnt), 32'h0);
    count_to_tick(n);
    check("post_reset_tick_cycle", 32'(n), 32'(SC));
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
